// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports, one gated synchronous write port,
// optional write-to-read forwarding, optional hardwired zero entry and a sequenced clear engine.
module reg_file_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter bit          ZERO_REG   = 1'b0,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] IN,
    input  logic [ADDR_WIDTH-1:0] INADDRESS,
    input  logic                  WRITE,
    input  logic                  BUSYWAIT,
    input  logic                  CLEAR,
    input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
    input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
    output logic [DATA_WIDTH-1:0] OUT1,
    output logic [DATA_WIDTH-1:0] OUT2,
    output logic                  READY
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [0:0] {StClearing, StIdle} state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic                    ready_q;
    logic [DATA_WIDTH-1:0]   regs_q [DEPTH];

    logic wr_zero;
    logic we;

    // A CLEAR accepted at an idle edge takes priority, so the coincident write is dropped.
    assign wr_zero = ZERO_REG && (INADDRESS == '0);
    assign we      = WRITE && !BUSYWAIT && ready_q && !RESET && !CLEAR && !wr_zero;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StClearing;
            idx_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                StClearing: begin
                    regs_q[idx_q] <= '0;
                    if (idx_q == ADDR_WIDTH'(DEPTH - 1)) begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StIdle: begin
                    if (CLEAR) begin
                        state_q <= StClearing;
                        idx_q   <= '0;
                        ready_q <= 1'b0;
                    end else if (we) begin
                        regs_q[INADDRESS] <= IN;
                    end
                end
            endcase
        end
    end

    always_comb begin
        OUT1 = '0;
        OUT2 = '0;
        if (ready_q && !(ZERO_REG && (OUT1ADDRESS == '0))) begin
            if (BYPASS && we && (INADDRESS == OUT1ADDRESS)) begin
                OUT1 = IN;
            end else begin
                OUT1 = regs_q[OUT1ADDRESS];
            end
        end
        if (ready_q && !(ZERO_REG && (OUT2ADDRESS == '0))) begin
            if (BYPASS && we && (INADDRESS == OUT2ADDRESS)) begin
                OUT2 = IN;
            end else begin
                OUT2 = regs_q[OUT2ADDRESS];
            end
        end
    end

    assign READY = ready_q;

endmodule
